// File: rtl/rv_decode_stage_pkg.sv
// Shared encodings for the RV32I/RV64I decode stage: base opcodes, operand/PC
// selector codes, immediate formats and the control-flow hold state.
package rv_decode_stage_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] PC_PLUS_4 = 2'd0;
    localparam logic [1:0] PC_JAL    = 2'd1;
    localparam logic [1:0] PC_JALR   = 2'd2;
    localparam logic [1:0] PC_BRANCH = 2'd3;

    localparam logic [1:0] A_REG = 2'd0;
    localparam logic [1:0] A_PC  = 2'd1;
    localparam logic [1:0] A_0   = 2'd2;

    localparam logic B_REG = 1'b0;
    localparam logic B_IMM = 1'b1;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef enum logic {
        ST_RUN,
        ST_WAIT_REDIRECT
    } dec_state_e;

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator: assembles the 32-bit immediate for the
// given format and sign-extends it from inst[31] to XLEN.
module rv_imm_gen
    import rv_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  imm_fmt_e        format,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;
    logic        unusedOpcode;

    // The opcode bits never contribute to any immediate.
    assign unusedOpcode = ^inst[6:0];

    always_comb begin
        imm32 = '0;
        case (format)
            IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm32 = {inst[31:12], 12'b0};
            IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/rv_decode_stage.sv
// Decode stage between fetch and execute: one output register with valid/ready
// on both sides, load-use bubble interlock and a hold until execute redirects.
module rv_decode_stage
    import rv_decode_stage_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int LOAD_BUBBLES = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic [1:0]      pc_sel,
    output logic [1:0]      a_sel,
    output logic            b_sel,
    output logic            illegal,
    output logic            stall,
    input  logic            redirect
);

    localparam logic [1:0] LD_RELOAD = (LOAD_BUBBLES > 0) ? 2'(LOAD_BUBBLES - 1) : 2'd0;

    imm_fmt_e        immFmt;
    logic [XLEN-1:0] immDec;
    logic [1:0]      pcSel, aSel;
    logic            bSel, isIllegal, usesRs1, usesRs2, isLoad, isCtrl;
    logic            accept, ldHazard, ldTransfer, outLdLive, trkLive;
    logic [4:0]      inRs1, inRs2, outRd;

    dec_state_e      state_q, state_d;
    logic [4:0]      ldRd_q, ldRd_d;
    logic [1:0]      ldCnt_q, ldCnt_d;
    logic            outValid_q, outIsLoad_q, illegal_q, bSel_q;
    logic [31:0]     outInst_q;
    logic [XLEN-1:0] outPc_q, imm_q;
    logic [1:0]      pcSel_q, aSel_q;

    always_comb begin
        immFmt    = IMM_NONE;
        pcSel     = PC_PLUS_4;
        aSel      = A_REG;
        bSel      = B_REG;
        isIllegal = 1'b0;
        usesRs1   = 1'b1;
        usesRs2   = 1'b0;
        isLoad    = 1'b0;
        isCtrl    = 1'b0;
        case (in_inst[6:0])
            OPC_OP_IMM: begin immFmt = IMM_I; bSel = B_IMM; end
            OPC_LOAD:   begin immFmt = IMM_I; bSel = B_IMM; isLoad = 1'b1; end
            OPC_JALR:   begin immFmt = IMM_I; bSel = B_IMM; pcSel = PC_JALR; isCtrl = 1'b1; end
            OPC_STORE:  begin immFmt = IMM_S; bSel = B_IMM; usesRs2 = 1'b1; end
            OPC_OP:     begin usesRs2 = 1'b1; end
            OPC_BRANCH: begin immFmt = IMM_B; pcSel = PC_BRANCH; usesRs2 = 1'b1; isCtrl = 1'b1; end
            OPC_LUI:    begin immFmt = IMM_U; aSel = A_0; bSel = B_IMM; usesRs1 = 1'b0; end
            OPC_AUIPC:  begin immFmt = IMM_U; aSel = A_PC; bSel = B_IMM; usesRs1 = 1'b0; end
            OPC_JAL:    begin immFmt = IMM_J; aSel = A_PC; bSel = B_IMM; pcSel = PC_JAL;
                              usesRs1 = 1'b0; isCtrl = 1'b1; end
            default:    begin isIllegal = 1'b1; usesRs1 = 1'b0; end
        endcase
    end

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst   (in_inst),
        .format (immFmt),
        .imm    (immDec)
    );

    assign inRs1 = in_inst[19:15];
    assign inRs2 = in_inst[24:20];
    assign outRd = outInst_q[11:7];

    // A load still sitting in the output register, or one that left within the
    // last LOAD_BUBBLES-1 cycles, blocks any consumer of its destination.
    assign outLdLive = outValid_q && outIsLoad_q && (outRd != 5'd0);
    assign trkLive   = (ldCnt_q != 2'd0);
    assign ldHazard  = (LOAD_BUBBLES > 0) &&
                       ((outLdLive && ((usesRs1 && inRs1 == outRd) || (usesRs2 && inRs2 == outRd))) ||
                        (trkLive && ((usesRs1 && inRs1 == ldRd_q) || (usesRs2 && inRs2 == ldRd_q))));

    assign in_ready = (!outValid_q || out_ready) && (state_q == ST_RUN) && !ldHazard && !redirect;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && accept && isCtrl) begin
            state_d = ST_WAIT_REDIRECT;
        end else if (state_q == ST_WAIT_REDIRECT && redirect) begin
            state_d = ST_RUN;
        end
    end

    assign ldTransfer = outValid_q && out_ready && outLdLive;

    always_comb begin
        ldRd_d  = ldRd_q;
        ldCnt_d = ldCnt_q;
        if (ldTransfer) begin
            ldRd_d  = outRd;
            ldCnt_d = LD_RELOAD;
        end else if (trkLive) begin
            ldCnt_d = ldCnt_q - 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            ldRd_q  <= '0;
            ldCnt_q <= '0;
        end else begin
            state_q <= state_d;
            ldRd_q  <= ldRd_d;
            ldCnt_q <= ldCnt_d;
        end
    end

    // Redirect squashes the held instruction; fields only change on accept.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            outValid_q  <= 1'b0;
            outIsLoad_q <= 1'b0;
            outInst_q   <= '0;
            outPc_q     <= '0;
            imm_q       <= '0;
            pcSel_q     <= PC_PLUS_4;
            aSel_q      <= A_REG;
            bSel_q      <= B_REG;
            illegal_q   <= 1'b0;
        end else if (redirect) begin
            outValid_q <= 1'b0;
        end else if (accept) begin
            outValid_q  <= 1'b1;
            outIsLoad_q <= isLoad;
            outInst_q   <= in_inst;
            outPc_q     <= in_pc;
            imm_q       <= immDec;
            pcSel_q     <= pcSel;
            aSel_q      <= aSel;
            bSel_q      <= bSel;
            illegal_q   <= isIllegal;
        end else if (out_ready) begin
            outValid_q <= 1'b0;
        end
    end

    assign out_valid = outValid_q;
    assign out_inst  = outInst_q;
    assign out_pc    = outPc_q;
    assign rs1       = outInst_q[19:15];
    assign rs2       = outInst_q[24:20];
    assign rd        = outRd;
    assign imm       = imm_q;
    assign pc_sel    = pcSel_q;
    assign a_sel     = aSel_q;
    assign b_sel     = bSel_q;
    assign illegal   = illegal_q;
    assign stall     = (state_q == ST_WAIT_REDIRECT);

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage at XLEN=64: one instance with one load
// bubble and a second with three bubbles for the interlock and reset cases.
module tb_rv_decode_stage;

    logic        clock;
    logic        reset_n;
    logic        inValid, inReady, outValid, outReady, redirect;
    logic [31:0] inInst, outInst;
    logic [63:0] inPc, outPc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  pcSel, aSel;
    logic        bSel, illegal, stall;

    logic        inValid2, inReady2, outValid2, outReady2, redirect2;
    logic [31:0] inInst2, outInst2;
    logic [63:0] inPc2, outPc2, imm2;
    logic [4:0]  rs1_2, rs2_2, rd2;
    logic [1:0]  pcSel2, aSel2;
    logic        bSel2, illegal2, stall2;

    int checks   = 0;
    int failures = 0;

    rv_decode_stage #(.XLEN(64), .LOAD_BUBBLES(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(inValid), .in_ready(inReady), .in_inst(inInst), .in_pc(inPc),
        .out_valid(outValid), .out_ready(outReady), .out_inst(outInst), .out_pc(outPc),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .pc_sel(pcSel), .a_sel(aSel), .b_sel(bSel), .illegal(illegal),
        .stall(stall), .redirect(redirect)
    );

    rv_decode_stage #(.XLEN(64), .LOAD_BUBBLES(3)) dut3 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(inValid2), .in_ready(inReady2), .in_inst(inInst2), .in_pc(inPc2),
        .out_valid(outValid2), .out_ready(outReady2), .out_inst(outInst2), .out_pc(outPc2),
        .rs1(rs1_2), .rs2(rs2_2), .rd(rd2), .imm(imm2),
        .pc_sel(pcSel2), .a_sel(aSel2), .b_sel(bSel2), .illegal(illegal2),
        .stall(stall2), .redirect(redirect2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] inst, input logic [63:0] pc);
        inValid = valid;
        inInst  = inst;
        inPc    = pc;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset_n = 1'b0; outReady = 1'b1; redirect = 1'b0;
        applyStimulus(1'b0, 32'h0, 64'h0);
        inValid2 = 1'b0; inInst2 = '0; inPc2 = '0; outReady2 = 1'b1; redirect2 = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        #1;
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_imm", imm, 0);
        checkOutput("rst_in_ready", inReady, 1);

        // addi x1,x2,-1
        applyStimulus(1'b1, 32'hFFF10093, 64'h1000);
        #1 checkOutput("addi_in_ready", inReady, 1);
        tick();
        applyStimulus(1'b0, 32'h0, 64'h0);
        #1;
        checkOutput("addi_valid", outValid, 1);
        checkOutput("addi_rd", rd, 1);
        checkOutput("addi_rs1", rs1, 2);
        checkOutput("addi_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("addi_b_sel", bSel, 1);
        checkOutput("addi_pc_sel", pcSel, 0);
        checkOutput("addi_pc", outPc, 64'h1000);
        tick();

        // back-pressure: second addi waits while out_ready is low
        outReady = 1'b0;
        applyStimulus(1'b1, 32'h00100093, 64'h2000);
        tick();
        applyStimulus(1'b1, 32'h00200113, 64'h2004);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bp_in_ready", inReady, 0);
            checkOutput("bp_hold_valid", outValid, 1);
            checkOutput("bp_hold_pc", outPc, 64'h2000);
            checkOutput("bp_hold_imm", imm, 1);
            tick();
        end
        outReady = 1'b1;
        #1 checkOutput("bp_release_ready", inReady, 1);
        tick();
        applyStimulus(1'b0, 32'h0, 64'h0);
        #1;
        checkOutput("bp_second_valid", outValid, 1);
        checkOutput("bp_second_pc", outPc, 64'h2004);
        checkOutput("bp_second_rd", rd, 2);
        tick();
        #1 checkOutput("bp_no_dup", outValid, 0);

        // lw x5,0(x1) then dependent add x6,x5,x7: one bubble
        applyStimulus(1'b1, 32'h0000A283, 64'h100);
        tick();
        applyStimulus(1'b1, 32'h00728333, 64'h104);
        #1;
        checkOutput("lu_hazard_ready", inReady, 0);
        checkOutput("lu_load_rd", rd, 5);
        tick();
        #1;
        checkOutput("lu_bubble", outValid, 0);
        checkOutput("lu_ready_after", inReady, 1);
        tick();
        applyStimulus(1'b0, 32'h0, 64'h0);
        #1;
        checkOutput("lu_dep_valid", outValid, 1);
        checkOutput("lu_dep_inst", outInst, 64'h00728333);
        checkOutput("lu_dep_rs2", rs2, 7);
        checkOutput("lu_dep_b_sel", bSel, 0);
        checkOutput("lu_dep_imm", imm, 0);

        // independent consumer and lw x0: no bubble
        applyStimulus(1'b1, 32'h0000A283, 64'h200);
        tick();
        applyStimulus(1'b1, 32'h00740333, 64'h204);
        #1 checkOutput("indep_ready", inReady, 1);
        tick();
        applyStimulus(1'b0, 32'h0, 64'h0);
        #1 checkOutput("indep_pc", outPc, 64'h204);
        applyStimulus(1'b1, 32'h0000A003, 64'h300);
        tick();
        applyStimulus(1'b1, 32'h00700333, 64'h304);
        #1 checkOutput("ldx0_ready", inReady, 1);
        tick();
        applyStimulus(1'b0, 32'h0, 64'h0);
        #1 checkOutput("ldx0_pc", outPc, 64'h304);

        // lui x3,0x80000 then sw x2,-4(x1)
        applyStimulus(1'b1, 32'h800001B7, 64'h400);
        tick();
        applyStimulus(1'b1, 32'hFE20AE23, 64'h404);
        #1;
        checkOutput("lui_imm", imm, 64'hFFFF_FFFF_8000_0000);
        checkOutput("lui_a_sel", aSel, 2);
        checkOutput("lui_rd", rd, 3);
        tick();
        applyStimulus(1'b0, 32'h0, 64'h0);
        #1;
        checkOutput("sw_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("sw_a_sel", aSel, 0);
        checkOutput("sw_b_sel", bSel, 1);

        // beq x1,x2,8: hold until redirect
        applyStimulus(1'b1, 32'h00208463, 64'h500);
        tick();
        applyStimulus(1'b1, 32'h00100093, 64'h508);
        #1;
        checkOutput("beq_imm", imm, 8);
        checkOutput("beq_pc_sel", pcSel, 3);
        checkOutput("beq_b_sel", bSel, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("beq_in_ready", inReady, 0);
            checkOutput("beq_stall", stall, 1);
            tick();
            #1;
        end
        redirect = 1'b1;
        #1 checkOutput("redir_ready", inReady, 0);
        tick();
        redirect = 1'b0;
        #1;
        checkOutput("redir_stall", stall, 0);
        checkOutput("redir_in_ready", inReady, 1);
        checkOutput("redir_flushed", outValid, 0);
        tick();
        applyStimulus(1'b0, 32'h0, 64'h0);
        #1;
        checkOutput("post_redir_pc", outPc, 64'h508);
        checkOutput("post_redir_pc_sel", pcSel, 0);

        // illegal opcode 0x7F is passed on without stalling
        applyStimulus(1'b1, 32'h0000007F, 64'h600);
        tick();
        applyStimulus(1'b1, 32'h00300093, 64'h604);
        #1;
        checkOutput("ill_flag", illegal, 1);
        checkOutput("ill_pc_sel", pcSel, 0);
        checkOutput("ill_stall", stall, 0);
        checkOutput("ill_imm", imm, 0);
        checkOutput("ill_b_sel", bSel, 0);
        checkOutput("ill_next_ready", inReady, 1);
        tick();
        applyStimulus(1'b0, 32'h0, 64'h0);
        #1;
        checkOutput("ill_next_flag", illegal, 0);
        checkOutput("ill_next_pc", outPc, 64'h604);
        tick();

        // three-bubble instance: lw x5 then add x6,x5,x7
        inValid2 = 1'b1; inInst2 = 32'h0000A283; inPc2 = 64'h700;
        tick();
        inInst2 = 32'h00728333; inPc2 = 64'h704;
        #1 checkOutput("b3_hazard_ready", inReady2, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("b3_bubble", outValid2, 0);
            checkOutput("b3_in_ready", inReady2, (i == 2) ? 64'd1 : 64'd0);
            tick();
        end
        inValid2 = 1'b0;
        #1;
        checkOutput("b3_dep_valid", outValid2, 1);
        checkOutput("b3_dep_inst", outInst2, 64'h00728333);

        // reset while waiting for redirect, output held and tracker live
        inValid2 = 1'b1; inInst2 = 32'h0000A283; inPc2 = 64'h800;
        tick();
        inInst2 = 32'h0100006F; inPc2 = 64'h804;
        #1 checkOutput("jal_in_ready", inReady2, 1);
        tick();
        outReady2 = 1'b0;
        inInst2 = 32'h00728333; inPc2 = 64'h808;
        #1;
        checkOutput("jal_stall", stall2, 1);
        checkOutput("jal_valid", outValid2, 1);
        checkOutput("jal_imm", imm2, 16);
        checkOutput("jal_pc_sel", pcSel2, 1);
        checkOutput("jal_a_sel", aSel2, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        outReady2 = 1'b1;
        #1;
        checkOutput("mrst_valid", outValid2, 0);
        checkOutput("mrst_stall", stall2, 0);
        checkOutput("mrst_imm", imm2, 0);
        checkOutput("mrst_inst", outInst2, 0);
        checkOutput("mrst_pc", outPc2, 0);
        checkOutput("mrst_regs", {rs1_2, rs2_2, rd2}, 0);
        checkOutput("mrst_sels", {pcSel2, aSel2, bSel2, illegal2}, 0);
        checkOutput("mrst_in_ready", inReady2, 1);
        inValid2 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
